// File: rtl/pipe_pkg.sv
// Shared definitions for the generic pipeline stage register and its neighbours.
// Holds the occupancy encoding, ID/EX control-bit positions and default widths.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } stage_state_e;

    // Bit positions inside the ID/EX control word
    localparam int CTRL_REGDST       = 0;
    localparam int CTRL_ALUSRC       = 1;
    localparam int CTRL_MEMTOREG     = 2;
    localparam int CTRL_REGWRITE     = 3;
    localparam int CTRL_MEMREAD      = 4;
    localparam int CTRL_MEMWRITE     = 5;
    localparam int CTRL_BRANCHJUMP   = 6;
    localparam int CTRL_BRANCHJUMP_HI = 7;
    localparam int CTRL_ALUOP        = 8;
    localparam int CTRL_ALUOP_HI     = 9;

    localparam int DEF_DATA_W = 138;
    localparam int DEF_CTRL_W = 10;
    localparam int DEF_CNT_W  = 16;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
// Sticks at all-ones; shared by the per-stage performance counters.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: valid/ready handshake with a two-entry skid buffer,
// synchronous flush, and all-zero control whenever the output slot holds a bubble.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CTRL_W = DEF_CTRL_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    stage_state_e      state;
    stage_state_e      nextState;
    logic              acc;
    logic              take;
    logic              loadMainIn;
    logic              loadMainSkid;
    logic              loadSkid;
    logic [CTRL_W-1:0] mainCtrl;
    logic [CTRL_W-1:0] skidCtrl;
    logic [DATA_W-1:0] mainData;
    logic [DATA_W-1:0] skidData;

    assign acc  = in_valid & in_ready;
    assign take = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState    = state;
        loadMainIn   = 1'b0;
        loadMainSkid = 1'b0;
        loadSkid     = 1'b0;
        case (state)
            EMPTY: begin
                if (acc) begin
                    nextState  = ONE;
                    loadMainIn = 1'b1;
                end
            end
            ONE: begin
                if (acc && take) begin
                    loadMainIn = 1'b1;
                end else if (acc) begin
                    nextState = FULL;
                    loadSkid  = 1'b1;
                end else if (take) begin
                    nextState = EMPTY;
                end
            end
            FULL: begin
                if (take) begin
                    nextState    = ONE;
                    loadMainSkid = 1'b1;
                end
            end
            default: nextState = EMPTY;
        endcase
        // A redirect squashes held entries and the input offered this same cycle
        if (flush) begin
            nextState    = EMPTY;
            loadMainIn   = 1'b0;
            loadMainSkid = 1'b0;
            loadSkid     = 1'b0;
        end
    end

    // Ready comes from state flops only, so no combinational path from out_ready
    always_comb begin
        in_ready  = (state != FULL);
        out_valid = (state != EMPTY);
        out_ctrl  = out_valid ? mainCtrl : '0;
        out_data  = mainData;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mainCtrl <= '0;
            mainData <= '0;
            skidCtrl <= '0;
            skidData <= '0;
        end else begin
            if (loadMainIn) begin
                mainCtrl <= in_ctrl;
                mainData <= in_data;
            end else if (loadMainSkid) begin
                mainCtrl <= skidCtrl;
                mainData <= skidData;
            end
            if (loadSkid) begin
                skidCtrl <= in_ctrl;
                skidData <= in_data;
            end
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_stallCnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (out_valid & ~out_ready & ~flush),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: queue-based occupancy model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_pipe_stage_reg;

    localparam int DW = 138;
    localparam int CW = 10;
    localparam int NW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [NW-1:0] stall_cnt;

    int nChecks = 0;
    int nFails  = 0;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          q[$];
    int            mCnt;
    logic [DW-1:0] mData;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a FIFO of at most two instructions; head is what the stage presents
    initial begin
        q.delete();
        mCnt  = 0;
        mData = '0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                q.delete();
                mCnt  = 0;
                mData = '0;
            end else begin
                automatic bit canAcc = in_valid && (q.size() < 2);
                automatic bit canTake = (q.size() > 0) && out_ready;
                if ((q.size() > 0) && !out_ready && !flush && mCnt < (2**NW - 1)) mCnt++;
                if (flush) begin
                    q.delete();
                end else begin
                    if (canTake) void'(q.pop_front());
                    if (canAcc) q.push_back('{c: in_ctrl, d: in_data});
                end
                if (q.size() > 0) mData = q[0].d;
            end
        end
    end

    always @(negedge clk) begin
        check("out_valid", out_valid, (q.size() > 0));
        check("out_ctrl", out_ctrl, (q.size() > 0) ? q[0].c : '0);
        check("out_data", out_data, mData);
        check("in_ready", in_ready, (q.size() < 2));
        check("stall_cnt", stall_cnt, mCnt);
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
        in_valid = v;
        in_ctrl  = c;
        in_data  = d;
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        offer(1'b0, '0, '0);

        // Reset then idle
        repeat (3) cycle();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_ctrl", out_ctrl, 0);
        check("rst_out_data", out_data, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_stall_cnt", stall_cnt, 0);
        rst_n = 1'b1;
        cycle();

        // Streaming at full rate
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            offer(1'b1, 10'h3FF, DW'(k));
            cycle();
            check("stream_valid", out_valid, 1);
            check("stream_data", out_data, DW'(k));
            check("stream_ctrl", out_ctrl, 10'h3FF);
            check("stream_ready", in_ready, 1);
        end
        offer(1'b0, '0, '0);
        cycle();
        check("stream_drain", out_valid, 0);

        // Back-pressure: A, B fill the stage, C waits upstream
        out_ready = 1'b0;
        offer(1'b1, 10'h155, DW'('hA));
        cycle();
        check("bp_A_data", out_data, DW'('hA));
        check("bp_A_ready", in_ready, 1);
        offer(1'b1, 10'h2AA, DW'('hB));
        cycle();
        check("bp_B_ready", in_ready, 0);
        check("bp_B_head", out_data, DW'('hA));
        offer(1'b1, 10'h0F0, DW'('hC));
        cycle();
        cycle();
        check("bp_stall3", stall_cnt, 3);
        check("bp_hold_ctrl", out_ctrl, 10'h155);
        out_ready = 1'b1;
        cycle();
        check("bp_out_B", out_data, DW'('hB));
        check("bp_out_B_ctrl", out_ctrl, 10'h2AA);
        cycle();
        check("bp_out_C", out_data, DW'('hC));
        check("bp_out_C_ctrl", out_ctrl, 10'h0F0);
        offer(1'b0, '0, '0);
        cycle();
        check("bp_empty", out_valid, 0);
        check("bp_stall_final", stall_cnt, 3);

        // Flush while FULL with a valid input offered
        out_ready = 1'b0;
        offer(1'b1, 10'h3FF, DW'('h11));
        cycle();
        offer(1'b1, 10'h3FF, DW'('h22));
        cycle();
        check("fl_full", in_ready, 0);
        offer(1'b1, 10'h3FF, DW'('hDD));
        flush = 1'b1;
        cycle();
        check("fl_valid", out_valid, 0);
        check("fl_ctrl", out_ctrl, 0);
        check("fl_ready", in_ready, 1);
        check("fl_stall", stall_cnt, 4);
        flush = 1'b0;
        offer(1'b0, '0, '0);
        cycle();
        check("fl_noD", out_valid, 0);

        // Flush from EMPTY drops an acceptable input; payload keeps the old head
        offer(1'b1, 10'h3FF, DW'('h77));
        flush = 1'b1;
        cycle();
        check("fl2_valid", out_valid, 0);
        check("fl2_data", out_data, DW'('h11));
        flush = 1'b0;
        out_ready = 1'b1;
        cycle();
        check("fl2_resume", out_data, DW'('h77));
        offer(1'b0, '0, '0);
        cycle();

        // Saturation with the stage FULL and stalled
        out_ready = 1'b0;
        offer(1'b1, 10'h001, DW'('h55));
        cycle();
        offer(1'b1, 10'h002, DW'('h66));
        cycle();
        offer(1'b0, '0, '0);
        repeat (20) cycle();
        check("sat_cnt", stall_cnt, 15);
        check("sat_full", in_ready, 0);

        // Asynchronous reset between edges
        #1 rst_n = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_ctrl", out_ctrl, 0);
        check("arst_ready", in_ready, 1);
        check("arst_cnt", stall_cnt, 0);
        check("arst_data", out_data, 0);
        #1 rst_n = 1'b1;
        cycle();
        check("arst_after", out_valid, 0);
        out_ready = 1'b1;
        offer(1'b1, 10'h0AA, DW'('h99));
        cycle();
        check("arst_resume", out_data, DW'('h99));
        offer(1'b0, '0, '0);
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
